// File: rtl/reg_read_port.sv
// Read port for the register bank: it captures one register by address and drives it on DOUT for HOLD cycles.
// It also has an auto-scan mode for the display. Define READ_PARITY_EN to add a registered even-parity output, DPar.
module reg_read_port #(
    parameter int WIDTH = 4,
    parameter int NREGS = 4,
    parameter int AW    = 2,
    parameter int HOLD  = 3
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [NREGS*WIDTH-1:0] Q_all,
    input  logic [AW-1:0]          Addr,
    input  logic                   Rn,
    input  logic                   Scan,
    output logic [WIDTH-1:0]       DOUT,
    output logic                   DValid,
    output logic [AW-1:0]          DAddr,
`ifdef READ_PARITY_EN
    output logic                   DPar,
`endif
    output logic                   Busy
);

    // state   | meaning
    // IDLE    | waiting for Rn low (priority) or Scan high
    // CAPTURE | latch the selected register into DOUT/DAddr, load hold counter
    // DRIVE   | DOUT valid; counter runs down to zero, then back to IDLE
    typedef enum logic [1:0] {IDLE, CAPTURE, DRIVE} state_t;

    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    state_t           state, state_nxt;
    logic [CW-1:0]    hold_cnt;
    logic [AW-1:0]    lat_addr;
    logic [AW-1:0]    scan_idx;
    logic             from_scan;
    logic             start_rd;
    logic             start_scan;
    logic             drive_done;
    logic [WIDTH-1:0] q_arr [NREGS];
    logic [WIDTH-1:0] q_sel;

    generate
        for (genvar i = 0; i < NREGS; i++) begin : g_unpack
            assign q_arr[i] = Q_all[i*WIDTH +: WIDTH];
        end
    endgenerate

    assign q_sel  = q_arr[lat_addr];
    assign DValid = (state == DRIVE);
    assign Busy   = (state != IDLE);

    always_comb begin
        state_nxt  = state;
        start_rd   = 1'b0;
        start_scan = 1'b0;
        drive_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (!Rn) begin
                    start_rd  = 1'b1;
                    state_nxt = CAPTURE;
                end else if (Scan) begin
                    start_scan = 1'b1;
                    state_nxt  = CAPTURE;
                end
            end
            CAPTURE: state_nxt = DRIVE;
            DRIVE: begin
                if (hold_cnt == '0) begin
                    drive_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            lat_addr  <= '0;
            from_scan <= 1'b0;
            scan_idx  <= '0;
            hold_cnt  <= '0;
            DOUT      <= '0;
            DAddr     <= '0;
`ifdef READ_PARITY_EN
            DPar      <= 1'b0;
`endif
        end else begin
            if (start_rd) begin
                lat_addr  <= Addr;
                from_scan <= 1'b0;
            end else if (start_scan) begin
                lat_addr  <= scan_idx;
                from_scan <= 1'b1;
            end

            if (state == CAPTURE) begin
                DOUT     <= q_sel;
                DAddr    <= lat_addr;
                hold_cnt <= CW'(HOLD - 1);
`ifdef READ_PARITY_EN
                DPar     <= ^q_sel;
`endif
            end else if (state == DRIVE && !drive_done) begin
                hold_cnt <= hold_cnt - CW'(1);
            end

            // The scan index moves on only after a scan read, so single reads never disturb it.
            if (drive_done && from_scan) begin
                scan_idx <= scan_idx + AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_reg_read_port.sv
// Self-checking bench for reg_read_port: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level timing model.
module tb_reg_read_port;

    localparam int WIDTH = 4;
    localparam int NREGS = 4;
    localparam int AW    = 2;
    localparam int HOLD  = 3;

    logic                   clock = 1'b0;
    logic                   resetn = 1'b0;
    logic [NREGS*WIDTH-1:0] Q_all = '0;
    logic [AW-1:0]          Addr = '0;
    logic                   Rn = 1'b1;
    logic                   Scan = 1'b0;
    logic [WIDTH-1:0]       DOUT;
    logic                   DValid;
    logic [AW-1:0]          DAddr;
    logic                   Busy;
`ifdef READ_PARITY_EN
    logic                   DPar;
`endif

    int checks = 0;
    int failures = 0;
    bit mdl_on = 1'b0;

    reg_read_port #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW), .HOLD(HOLD)) dut (
        .clock  (clock),
        .resetn (resetn),
        .Q_all  (Q_all),
        .Addr   (Addr),
        .Rn     (Rn),
        .Scan   (Scan),
        .DOUT   (DOUT),
        .DValid (DValid),
        .DAddr  (DAddr),
`ifdef READ_PARITY_EN
        .DPar   (DPar),
`endif
        .Busy   (Busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    function automatic logic [WIDTH-1:0] slice(input logic [NREGS*WIDTH-1:0] q, input int i);
        return q[i*WIDTH +: WIDTH];
    endfunction

    // Transaction model: a read accepted at edge s is busy through edge s+HOLD, valid
    // from edge s+1 through s+HOLD, and the port can accept again after edge s+HOLD+1.
    int               cyc = 0;
    int               m_start = -100;
    int               m_end = -100;
    int               m_addr = 0;
    int               m_sidx = 0;
    bit               m_from_scan = 1'b0;
    logic [WIDTH-1:0] e_dout = '0;
    logic [AW-1:0]    e_daddr = '0;
    bit               e_busy = 1'b0;
    bit               e_dvalid = 1'b0;

    initial begin
        forever begin
            @(posedge clock or negedge resetn);
            if (!resetn) begin
                cyc = 0; m_start = -100; m_end = -100; m_addr = 0; m_sidx = 0;
                m_from_scan = 1'b0; e_dout = '0; e_daddr = '0; e_busy = 1'b0; e_dvalid = 1'b0;
            end else begin
                cyc++;
                if (cyc > m_end && (!Rn || Scan)) begin
                    m_start     = cyc;
                    m_end       = cyc + HOLD + 1;
                    m_from_scan = Rn;
                    m_addr      = !Rn ? int'(Addr) : m_sidx;
                end
                if (cyc == m_start + 1) begin
                    e_dout  = slice(Q_all, m_addr);
                    e_daddr = AW'(m_addr);
                end
                if (cyc == m_end && m_from_scan) m_sidx = (m_sidx + 1) % NREGS;
                e_busy   = (cyc >= m_start) && (cyc <= m_start + HOLD);
                e_dvalid = (cyc >= m_start + 1) && (cyc <= m_start + HOLD);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (mdl_on) begin
                check("cmp_busy", Busy, e_busy);
                check("cmp_dvalid", DValid, e_dvalid);
                check("cmp_dout", DOUT, e_dout);
                check("cmp_daddr", DAddr, e_daddr);
`ifdef READ_PARITY_EN
                check("cmp_dpar", DPar, ^e_dout);
`endif
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    int nhi;
    int first;
    int rises;
    int rn_phase;
    bit pv;
    logic [AW-1:0]    got_a [$];
    logic [WIDTH-1:0] got_d [$];
    logic [AW-1:0]    exp_a [9] = '{0, 1, 2, 3, 0, 1, 2, 2, 3};
    logic [WIDTH-1:0] exp_d [9] = '{1, 2, 3, 4, 1, 2, 3, 3, 4};

    initial begin
        resetn = 1'b0;
        step(); step();
        check("rst_dout", DOUT, 0);
        check("rst_dvalid", DValid, 0);
        check("rst_daddr", DAddr, 0);
        check("rst_busy", Busy, 0);
        resetn = 1'b1;
        mdl_on = 1'b1;
        step();

        // Single read of reg 1 from 16'hA5C3 (expected nibble 4'hC).
        Q_all = 16'hA5C3; Addr = 1; Rn = 0;
        step(); Rn = 1;
        check("rd1_capture_busy", Busy, 1);
        check("rd1_capture_dvalid", DValid, 0);
        nhi = 0; first = -1;
        for (int k = 1; k <= HOLD + 2; k++) begin
            step();
            if (DValid) begin
                nhi++;
                if (first < 0) first = k;
                check("rd1_dout", DOUT, 4'hC);
                check("rd1_daddr", DAddr, 1);
            end
        end
        check("rd1_len", nhi, 3);
        check("rd1_first", first, 1);
        check("rd1_idle", Busy, 0);
        check("rd1_dout_held", DOUT, 4'hC);

        // Captured data must not follow Q_all during DRIVE.
        Q_all = 16'hA5C3; Addr = 0; Rn = 0;
        step(); Rn = 1;
        step();
        check("stab_first", DOUT, 4'h3);
        Q_all[3:0] = 4'hF;
        for (int k = 0; k < HOLD; k++) begin
            step();
            check("stab_dout", DOUT, 4'h3);
        end
        step();

        // A request while busy is dropped.
        Q_all = 16'hA5C3; Addr = 0; Rn = 0;
        step(); Rn = 1;
        nhi = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 1) begin Rn = 0; Addr = 3; end
            else if (k == 2) Rn = 1;
            if (DValid) begin
                nhi++;
                check("ign_daddr", DAddr, 0);
            end
        end
        check("ign_len", nhi, HOLD);
        check("ign_idle", Busy, 0);

        // Scan walk with wrap; a single read of reg 2 interrupts it mid-scan.
        Q_all = 16'h4321; Scan = 1; rises = 0; rn_phase = 0; pv = 0;
        for (int k = 0; k < 100 && rises < 9; k++) begin
            step();
            if (DValid && !pv) begin
                got_a.push_back(DAddr);
                got_d.push_back(DOUT);
                rises++;
                if (rises == 6) begin Rn = 0; Addr = 2; rn_phase = 1; end
            end else if (rn_phase == 1 && !Busy) begin
                rn_phase = 2;
            end else if (rn_phase == 2) begin
                Rn = 1; rn_phase = 3;
            end
            pv = DValid;
        end
        Scan = 0;
        check("scan_count", rises, 9);
        for (int i = 0; i < 9; i++) begin
            if (i < got_a.size()) begin
                check($sformatf("scan_daddr_%0d", i), got_a[i], exp_a[i]);
                check($sformatf("scan_dout_%0d", i), got_d[i], exp_d[i]);
            end
        end
        for (int k = 0; k < 20 && Busy; k++) step();
        check("scan_idle", Busy, 0);

`ifdef READ_PARITY_EN
        Q_all = 16'h0057; Addr = 0; Rn = 0;
        step(); Rn = 1; step();
        check("par_0111", DPar, 1);
        for (int k = 0; k < HOLD + 1; k++) step();
        Addr = 1; Rn = 0;
        step(); Rn = 1; step();
        check("par_0101", DPar, 0);
        for (int k = 0; k < HOLD + 1; k++) step();
`endif

        // Asynchronous reset in the middle of a drive of reg 2.
        Q_all = 16'hA5C3; Addr = 2; Rn = 0;
        step(); Rn = 1; step();
        check("rstd_dvalid_pre", DValid, 1);
        check("rstd_dout_pre", DOUT, 4'h5);
        #1 resetn = 0;
        #1;
        check("rstd_dout", DOUT, 0);
        check("rstd_dvalid", DValid, 0);
        check("rstd_busy", Busy, 0);
        check("rstd_daddr", DAddr, 0);
        step();
        resetn = 1;
        step();
        check("rstd_after_busy", Busy, 0);
        check("rstd_after_dvalid", DValid, 0);

        // Randomized traffic checked by the model every cycle.
        for (int k = 0; k < 1500; k++) begin
            Q_all = 16'($urandom);
            Addr  = AW'($urandom_range(0, NREGS - 1));
            Rn    = ($urandom_range(0, 4) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 15) == 0) Scan = ~Scan;
            if ($urandom_range(0, 299) == 0) begin
                resetn = 0;
                step();
                resetn = 1;
            end
            step();
        end
        Rn = 1; Scan = 0;
        for (int k = 0; k < HOLD + 3; k++) step();
        check("end_idle", Busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
